// File: rtl/conv_pkg.sv
// conv_pkg: shared pixel width for the convolution pipeline.
package conv_pkg;
    localparam int PIXEL_W = 8;
endpackage

// File: rtl/conv_win_3x3.sv
// conv_win_3x3: builds 3x3 windows from a stream of 3-pixel columns.
// Two column registers (L, C) plus the incoming column form each window.
// Each line ends with a FLUSH cycle that emits the final window, padded on the right.
// Optional build macro CONV_WIN_BORDER_REPLICATE_EN: when defined, border
// columns replicate the edge column. Otherwise (default) they are zero.
module conv_win_3x3 (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             in_vld_i,
    output logic                             in_rdy_o,
    input  logic [3*conv_pkg::PIXEL_W-1:0]   col_i,
    input  logic                             sof_i,
    input  logic                             eol_i,
    output logic                             out_vld_o,
    input  logic                             out_rdy_i,
    output logic [9*conv_pkg::PIXEL_W-1:0]   win_o,
    output logic                             out_sof_o,
    output logic                             out_eol_o
);
    localparam int P = conv_pkg::PIXEL_W;

`ifdef CONV_WIN_BORDER_REPLICATE_EN
    localparam logic [3*P-1:0] PAD_MASK = '1;
`else
    localparam logic [3*P-1:0] PAD_MASK = '0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3*P-1:0]     l_col_q, l_col_d;
    logic [3*P-1:0]     c_col_q, c_col_d;
    logic [9*P-1:0]     win_q, win_d;
    logic               out_vld_q, out_vld_d;
    logic               out_sof_q, out_sof_d;
    logic               out_eol_q, out_eol_d;
    logic               pend_sof_q, pend_sof_d;
    logic               advance;
    logic               accept;

    // Border column: the edge column itself, or all zeros.
    function automatic logic [3*P-1:0] pad(input logic [3*P-1:0] col);
        pad = col & PAD_MASK;
    endfunction

    // Place three columns side by side; element index is row*3+col, col 0 on the left.
    function automatic logic [9*P-1:0] make_win(input logic [3*P-1:0] l,
                                                input logic [3*P-1:0] c,
                                                input logic [3*P-1:0] r);
        make_win = '0;
        for (int row = 0; row < 3; row++) begin
            make_win[(row*3+0)*P +: P] = l[row*P +: P];
            make_win[(row*3+1)*P +: P] = c[row*P +: P];
            make_win[(row*3+2)*P +: P] = r[row*P +: P];
        end
    endfunction

    assign advance   = !out_vld_q || out_rdy_i;
    assign in_rdy_o  = advance && (state_q != FLUSH);
    assign accept    = in_vld_i && in_rdy_o;
    assign out_vld_o = out_vld_q;
    assign win_o     = win_q;
    assign out_sof_o = out_sof_q;
    assign out_eol_o = out_eol_q;

    // Next-state, column shift and output-window selection.
    always_comb begin
        state_d    = state_q;
        l_col_d    = l_col_q;
        c_col_d    = c_col_q;
        win_d      = win_q;
        pend_sof_d = pend_sof_q;
        out_vld_d  = out_vld_q && !out_rdy_i;
        out_sof_d  = out_sof_q;
        out_eol_d  = out_eol_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    c_col_d    = col_i;
                    l_col_d    = pad(col_i);
                    pend_sof_d = sof_i;
                    state_d    = eol_i ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (sof_i) begin
                        // A mid-line sof restarts the line and drops the old columns.
                        c_col_d    = col_i;
                        l_col_d    = pad(col_i);
                        pend_sof_d = 1'b1;
                    end else begin
                        win_d      = make_win(l_col_q, c_col_q, col_i);
                        l_col_d    = c_col_q;
                        c_col_d    = col_i;
                        out_vld_d  = 1'b1;
                        out_sof_d  = pend_sof_q;
                        out_eol_d  = 1'b0;
                        pend_sof_d = 1'b0;
                    end
                    state_d = eol_i ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (advance) begin
                    win_d      = make_win(l_col_q, c_col_q, pad(c_col_q));
                    out_vld_d  = 1'b1;
                    out_eol_d  = 1'b1;
                    out_sof_d  = pend_sof_q;
                    pend_sof_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, column and output registers, cleared asynchronously by arst_n.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            l_col_q    <= '0;
            c_col_q    <= '0;
            win_q      <= '0;
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eol_q  <= 1'b0;
            pend_sof_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_col_q    <= l_col_d;
            c_col_q    <= c_col_d;
            win_q      <= win_d;
            out_vld_q  <= out_vld_d;
            out_sof_q  <= out_sof_d;
            out_eol_q  <= out_eol_d;
            pend_sof_q <= pend_sof_d;
        end
    end
endmodule

// File: tb/tb_conv_win_3x3.sv
// tb_conv_win_3x3: directed table, hand-written corner cases and random lines
// checked against a line-level window model kept in this bench.
module tb_conv_win_3x3;
    localparam int P = conv_pkg::PIXEL_W;

    logic             clk;
    logic             arst_n;
    logic             in_vld_i;
    logic             in_rdy_o;
    logic [3*P-1:0]   col_i;
    logic             sof_i;
    logic             eol_i;
    logic             out_vld_o;
    logic             out_rdy_i;
    logic [9*P-1:0]   win_o;
    logic             out_sof_o;
    logic             out_eol_o;

    conv_win_3x3 dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_vld_i  (in_vld_i),
        .in_rdy_o  (in_rdy_o),
        .col_i     (col_i),
        .sof_i     (sof_i),
        .eol_i     (eol_i),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .win_o     (win_o),
        .out_sof_o (out_sof_o),
        .out_eol_o (out_eol_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9*P-1:0] win;
        logic           sof;
        logic           eol;
    } exp_t;

    typedef struct {
        logic           in_vld;
        logic [P-1:0]   bot;
        logic           sof;
        logic           eol;
        logic           exp_vld;
        logic           exp_rdy;
        logic [3*P-1:0] exp_l;
        logic [3*P-1:0] exp_c;
        logic [3*P-1:0] exp_r;
        logic           exp_sof;
        logic           exp_eol;
    } vec_t;

    int             checks = 0;
    int             failures = 0;
    int             win_count = 0;
    logic           last_accept;
    exp_t           exp_q[$];
    logic [3*P-1:0] line_cols[$];
    logic           line_sof;
    logic           in_line;
    vec_t           vecs[11];

    function automatic logic [3*P-1:0] padCol(input logic [3*P-1:0] c);
`ifdef CONV_WIN_BORDER_REPLICATE_EN
        return c;
`else
        return (c & '0);
`endif
    endfunction

    // Column with distinct top/mid/bottom pixels derived from the bottom value.
    function automatic logic [3*P-1:0] colv(input logic [P-1:0] b);
        logic [P-1:0] mid;
        logic [P-1:0] top;
        mid = b + P'(50);
        top = b + P'(100);
        return {b, mid, top};
    endfunction

    function automatic logic [9*P-1:0] mkWin(input logic [3*P-1:0] l,
                                             input logic [3*P-1:0] c,
                                             input logic [3*P-1:0] r);
        logic [9*P-1:0] w;
        w = '0;
        for (int row = 0; row < 3; row++) begin
            w[(row*3+0)*P +: P] = l[row*P +: P];
            w[(row*3+1)*P +: P] = c[row*P +: P];
            w[(row*3+2)*P +: P] = r[row*P +: P];
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [71:0] actual,
                               input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3*P-1:0] c,
                                 input logic s, input logic e);
        in_vld_i = v;
        col_i    = c;
        sof_i    = s;
        eol_i    = e;
    endtask

    // Line-level model: windows are centred on each pixel with padding at both ends.
    task automatic modelAccept(input logic [3*P-1:0] c, input logic s, input logic e);
        exp_t ew;
        int   n;
        int   x;
        logic [3*P-1:0] left;
        if (!in_line || s) begin
            line_cols.delete();
            line_sof = s;
            in_line  = 1'b1;
        end
        line_cols.push_back(c);
        n = line_cols.size();
        if (n >= 2) begin
            x = n - 2;
            if (x == 0) left = padCol(line_cols[0]);
            else        left = line_cols[x-1];
            ew.win = mkWin(left, line_cols[x], line_cols[x+1]);
            ew.sof = (x == 0) ? line_sof : 1'b0;
            ew.eol = 1'b0;
            exp_q.push_back(ew);
        end
        if (e) begin
            if (n >= 2) left = line_cols[n-2];
            else        left = padCol(line_cols[0]);
            ew.win = mkWin(left, line_cols[n-1], padCol(line_cols[n-1]));
            ew.sof = (n == 1) ? line_sof : 1'b0;
            ew.eol = 1'b1;
            exp_q.push_back(ew);
            in_line = 1'b0;
        end
    endtask

    task automatic observe();
        exp_t e;
        last_accept = 1'b0;
        if (out_vld_o && out_rdy_i) begin
            win_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_window actual=%h required=none", win_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_win", win_o, e.win);
                checkOutput("sb_sof", out_sof_o, e.sof);
                checkOutput("sb_eol", out_eol_o, e.eol);
            end
        end
        if (in_vld_i && in_rdy_o) begin
            modelAccept(col_i, sof_i, eol_i);
            last_accept = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        in_line = 1'b0;
        line_cols.delete();
        exp_q.delete();
    endtask

    // Main sequence: reset, table, stall, mid-line reset, random lines.
    initial begin
        int             cycles;
        int             lines_left;
        int             pos;
        int             len;
        int             base_count;
        logic           pending;
        logic           bs;
        logic           be;
        logic [31:0]    r32;
        logic [3*P-1:0] cap_win;

        in_line = 1'b0;
        line_sof = 1'b0;
        last_accept = 1'b0;
        arst_n = 1'b0;
        out_rdy_i = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        vecs[0]  = '{1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, padCol(colv(8'd1)), colv(8'd1), colv(8'd2), 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b1, colv(8'd1), colv(8'd2), colv(8'd3), 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, colv(8'd2), colv(8'd3), colv(8'd4), 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, colv(8'd3), colv(8'd4), padCol(colv(8'd4)), 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, padCol(colv(8'd7)), colv(8'd7), padCol(colv(8'd7)), 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0};

        #2;
        checkOutput("reset_out_vld", out_vld_o, 1'b0);
        checkOutput("reset_out_sof", out_sof_o, 1'b0);
        checkOutput("reset_out_eol", out_eol_o, 1'b0);
        checkOutput("reset_win", win_o, '0);
        checkOutput("reset_in_rdy", in_rdy_o, 1'b1);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].in_vld, colv(vecs[i].bot), vecs[i].sof, vecs[i].eol);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_in_rdy", i), in_rdy_o, vecs[i].exp_rdy);
            checkOutput($sformatf("tbl%0d_out_vld", i), out_vld_o, vecs[i].exp_vld);
            if (vecs[i].exp_vld) begin
                checkOutput($sformatf("tbl%0d_win", i), win_o,
                            mkWin(vecs[i].exp_l, vecs[i].exp_c, vecs[i].exp_r));
                checkOutput($sformatf("tbl%0d_sof", i), out_sof_o, vecs[i].exp_sof);
                checkOutput($sformatf("tbl%0d_eol", i), out_eol_o, vecs[i].exp_eol);
            end
            observe();
            @(posedge clk);
            #1;
        end

        // Backpressure in the middle of a line: everything must freeze.
        applyStimulus(1'b1, colv(8'd11), 1'b1, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd12), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd13), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd14), 1'b0, 1'b0);
        out_rdy_i = 1'b0;
        #1;
        cap_win = win_o[3*P-1:0];
        checkOutput("stall_win_expected", win_o, mkWin(colv(8'd11), colv(8'd12), colv(8'd13)));
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stall%0d_in_rdy", k), in_rdy_o, 1'b0);
            checkOutput($sformatf("stall%0d_out_vld", k), out_vld_o, 1'b1);
            checkOutput($sformatf("stall%0d_win", k), win_o[3*P-1:0], cap_win);
            tick();
            #1;
        end
        out_rdy_i = 1'b1;
        tick();
        applyStimulus(1'b1, colv(8'd15), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd16), 1'b0, 1'b1); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("stall_drained", exp_q.size(), 0);

        // Reset mid-line, then a fresh 3-beat line with no stale columns.
        applyStimulus(1'b1, colv(8'd9), 1'b1, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd10), 1'b0, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        arst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_out_vld", out_vld_o, 1'b0);
        checkOutput("midreset_win", win_o, '0);
        checkOutput("midreset_in_rdy", in_rdy_o, 1'b1);
        tick();
        arst_n = 1'b1;
        base_count = win_count;
        applyStimulus(1'b1, colv(8'd5), 1'b1, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd6), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, colv(8'd8), 1'b0, 1'b1); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("midreset_window_count", win_count - base_count, 3);
        checkOutput("midreset_drained", exp_q.size(), 0);

        // Random lines with random valid gaps and random backpressure.
        lines_left = 40;
        pending = 1'b0;
        pos = 0;
        len = 1;
        cycles = 0;
        while ((lines_left > 0 || pending) && cycles < 4000) begin
            if (!pending && lines_left > 0 && $urandom_range(3) != 0) begin
                if (pos == 0) len = $urandom_range(1, 6);
                bs = (pos == 0) || ($urandom_range(15) == 0);
                be = (pos == len - 1);
                r32 = $urandom;
                applyStimulus(1'b1, r32[3*P-1:0], bs, be);
                pending = 1'b1;
                pos++;
                if (be) begin
                    pos = 0;
                    lines_left--;
                end
            end else if (!pending) begin
                in_vld_i = 1'b0;
            end
            out_rdy_i = ($urandom_range(3) != 0);
            tick();
            cycles++;
            if (last_accept) pending = 1'b0;
        end
        if (cycles >= 4000) begin
            checks++;
            failures++;
            $display("[TB] FAIL random_timeout actual=%0d required=<4000", cycles);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        out_rdy_i = 1'b1;
        repeat (4) tick();
        checkOutput("random_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
